// File: rtl/pipe_stage_register.sv
// pipe_stage_register
//   Generic inter-stage pipeline register with a valid/ready handshake and a
//   flush that inserts a bubble. It replaces the fixed enable-only registers
//   between pipeline stages. Stalls come from downstream backpressure.
//
//   Build option: define PIPE_STAGE_REGISTER_SKID_EN to get a two-entry skid
//   buffer with a registered in_ready_o. Leave it undefined for a single entry
//   with a combinational in_ready_o. The port list is the same in both builds.
//
// Ports
//   clk_i        rising-edge clock
//   reset_n_i    synchronous reset, active low, has priority over everything
//   flush_i      drop every held entry this cycle
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept (transfer on in_valid_i && in_ready_o)
//   in_data_i    upstream payload, WIDTH bits
//   out_valid_o  payload available downstream
//   out_ready_i  downstream accepts (transfer on out_valid_o && out_ready_i)
//   out_data_o   registered payload to the next stage, WIDTH bits
module pipe_stage_register #(
    parameter int unsigned      WIDTH          = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE    = {32'h00000013, 32'h0},
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

`ifdef PIPE_STAGE_REGISTER_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;
`else
    typedef enum logic {S_EMPTY, S_FULL} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire;

`ifdef PIPE_STAGE_REGISTER_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Ready depends only on the state register, so out_ready_i never reaches
    // in_ready_o combinationally.
    assign in_ready_o = (state_q != S_SKID);
`else
    // Single entry: a slot frees up in the same cycle the held entry leaves.
    assign in_ready_o = !out_valid_o || out_ready_i;
`endif

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush_i) begin
            // Handshakes in this cycle are discarded; the bubble is the result.
            state_d = S_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = RESET_VALUE;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
                skid_d = RESET_VALUE;
`endif
            end
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d = S_FULL;
                        main_d  = in_data_i;
                    end
                end
                S_FULL: begin
                    if (in_fire && out_ready_i) begin
                        main_d = in_data_i;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind main.
                        state_d = S_SKID;
                        skid_d  = in_data_i;
`endif
                    end else if (out_ready_i) begin
                        // Main keeps its payload so out_data_o holds when idle.
                        state_d = S_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_REGISTER_SKID_EN
                S_SKID: begin
                    if (out_ready_i) begin
                        state_d = S_FULL;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VALUE;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
            skid_q  <= RESET_VALUE;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: two instances share the stimulus, one with
// CLEAR_ON_FLUSH=1 and one with CLEAR_ON_FLUSH=0. Each instance is compared
// every cycle against a queue-style occupancy model.
module tb_pipe_stage_register;

    localparam logic [63:0] RST_VAL = 64'h00000013_00000000;
`ifdef PIPE_STAGE_REGISTER_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        rdy [2];
    logic        vld [2];
    logic [63:0] dout [2];

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_register #(.WIDTH(64), .RESET_VALUE(RST_VAL), .CLEAR_ON_FLUSH(1'b1)) u_clr (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_data_i(in_data),
        .out_valid_o(vld[0]), .out_ready_i(out_ready), .out_data_o(dout[0]));

    pipe_stage_register #(.WIDTH(64), .RESET_VALUE(RST_VAL), .CLEAR_ON_FLUSH(1'b0)) u_hold (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_data_i(in_data),
        .out_valid_o(vld[1]), .out_ready_i(out_ready), .out_data_o(dout[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: up to CAP entries in order, plus the value the output register
    // shows while nothing is held.
    logic [63:0] m_ent [2][2];
    int          m_cnt [2];
    logic [63:0] m_hold [2];

    function automatic logic exp_rdy(input int k);
        if (CAP == 2) return m_cnt[k] < 2;
        return (m_cnt[k] == 0) || out_ready;
    endfunction

    task automatic model_step(input int k);
        logic push, pop;
        push = in_valid && exp_rdy(k);
        pop  = (m_cnt[k] > 0) && out_ready;
        if (!rst_n) begin
            m_cnt[k]  = 0;
            m_hold[k] = RST_VAL;
        end else if (flush) begin
            if (k == 0)           m_hold[k] = RST_VAL;
            else if (m_cnt[k] > 0) m_hold[k] = m_ent[k][0];
            m_cnt[k] = 0;
        end else begin
            if (pop) begin
                m_hold[k]   = m_ent[k][0];
                m_ent[k][0] = m_ent[k][1];
                m_cnt[k]--;
            end
            if (push) begin
                m_ent[k][m_cnt[k]] = in_data;
                m_cnt[k]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d_in_ready", k), 64'(rdy[k]), 64'(exp_rdy(k)));
            chk($sformatf("i%0d_out_valid", k), 64'(vld[k]), 64'(m_cnt[k] > 0));
            chk($sformatf("i%0d_out_data", k), dout[k],
                (m_cnt[k] > 0) ? m_ent[k][0] : m_hold[k]);
        end
    endtask

    // One clock: drive inputs at negedge, check the current outputs, then
    // advance the model on the rising edge.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [63:0] d, input logic ordy);
        @(negedge clk);
        rst_n = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (armed) check_all();
        @(posedge clk);
        model_step(0);
        model_step(1);
        armed = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_vld"}, 64'(vld[k]), 64'd0);
            chk({tag, "_data"}, dout[k], RST_VAL);
            chk({tag, "_rdy"}, 64'(rdy[k]), 64'd1);
        end
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_hold[0] = RST_VAL; m_hold[1] = RST_VAL;

        // Reset held with input activity.
        cycle(1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b1);
        check_reset_state("reset");

        // Streaming at full rate.
        cycle(1'b1, 1'b0, 1'b1, 64'h1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 64'h2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 64'h3, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);

        // Backpressure: A held, B offered while stalled.
        cycle(1'b1, 1'b0, 1'b1, 64'hA, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 64'hB, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);

        // Flush with both entries held and C offered.
        cycle(1'b1, 1'b0, 1'b1, 64'hA, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 64'hB, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 64'hC, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);

        // Flush with payload hold on instance 1, then a fresh push.
        cycle(1'b1, 1'b0, 1'b1, 64'h55, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 64'h66, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);

        // Reset and flush together while full.
        cycle(1'b1, 1'b0, 1'b1, 64'h77, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 64'h88, 1'b0);
        check_reset_state("rst_flush");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  ($urandom_range(0, 2) != 0));
        end
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_register.md
Name: pipe_stage_register

Overview:
- Parametrised pipeline stage register with valid/ready handshake, flush, and a two-entry skid buffer.
- Replaces the fixed-width enable-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Stalls come from downstream backpressure (out_ready) rather than a global enable.
- Flushes insert a bubble carrying a configurable reset payload, e.g. NOP instruction plus zero PC.

Parameters:
- WIDTH, 64, payload width in bits (bundle of stage fields, packed by the instantiating stage).
- RESET_VALUE, {32'h00000013, 32'h0}, payload driven on out_data after reset and, when CLEAR_ON_FLUSH=1, after flush.
- CLEAR_ON_FLUSH, 1, 1: flush loads RESET_VALUE into the payload registers; 0: flush clears valid state only and the payload holds.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low, sampled on rising edge of clk.
- flush  input  1  discard all held entries this cycle.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  payload available downstream.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  output  WIDTH  payload to next stage.

Behaviour:
- All state updates on posedge clk; reset_n=0 has priority over everything.
- Reset values: out_valid=0, in_ready=1 (first cycle after reset), out_data=RESET_VALUE, skid entry = RESET_VALUE, state=EMPTY.
- Flush, next priority after reset: state←EMPTY, out_valid←0, in_ready←1. Payloads←RESET_VALUE when CLEAR_ON_FLUSH=1.
- An in or out handshake in the flush cycle is discarded; the out transfer still counts as consumed downstream.
- Latency: 1 cycle from an accepted input to out_valid when EMPTY. Throughput is 1 transfer/cycle when out_ready is held at 1.
- Ordering is strictly FIFO; no payload is duplicated or dropped outside flush.
- States with skid: EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
  - EMPTY, in accepted → FULL, main←in_data.
  - FULL, in accepted and out_ready → FULL, main←in_data.
  - FULL, in accepted and !out_ready → SKID, skid←in_data, main holds.
  - FULL, no in and out_ready → EMPTY.
  - SKID, out_ready → FULL, main←skid. No input is accepted in SKID because in_ready=0.
  - SKID, !out_ready → hold.
- in_ready with skid is a register output: in_ready = (state != SKID). There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). out_data = main register, always registered.
- out_data holds its last value while out_valid=0, except after reset or a clearing flush.
- Simultaneous reset_n=0 and flush: reset wins; the result is identical to reset.
- Payload width: no truncation or extension inside the block; in_data and out_data are exactly WIDTH bits.

Optional Feature:
- Macro: PIPE_STAGE_REGISTER_SKID_EN.
- Defined: two-entry skid behaviour as above; in_ready is registered, so the block breaks the ready timing path.
- Undefined: single entry, states EMPTY/FULL only, no skid register.
  - in_ready = !out_valid || out_ready, a combinational path.
  - FULL with in accepted and out_ready: main←in_data.
  - FULL with !out_ready: hold, in_ready=0.
  - Flush and reset semantics unchanged.
- Port list is identical in both builds.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1, in_data=64'hDEAD → out_valid=0, out_data=64'h00000013_00000000, in_ready=1 on the first cycle after release.
- Streaming: out_ready=1, push A=64'h1, B=64'h2, C=64'h3 on consecutive cycles → out_data is 1, 2, 3 on the cycles after each push, out_valid=1 continuously, in_ready stays 1.
- Backpressure (SKID_EN defined): FULL with A; drop out_ready while pushing B → in_ready=0 next cycle; raise out_ready → A then B delivered, no loss. Undefined build: B is not accepted until out_ready=1.
- Flush in SKID state (A main, B skid): flush=1 plus in_valid with C → out_valid=0 next cycle, out_data=RESET_VALUE, C discarded, in_ready=1.
- CLEAR_ON_FLUSH=0: hold A=64'h55, flush → out_valid=0, out_data still 64'h55; the next push of 64'h66 appears after 1 cycle.
- Reset_n=0 and flush together while FULL → post-reset state identical to the reset test.
